// File: rtl/restoring_divider.sv
// 8-bit unsigned restoring divider: one shift/subtract iteration per clock,
// results and divide-by-zero flag registered and held until the next completion.
module restoring_divider (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  m_q, m_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic [16:0] step_s;

  // One restoring iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
  // Returns {A_next[8:0], Q_next[7:0]}.
  function automatic logic [16:0] div_step(input logic [8:0] a,
                                           input logic [7:0] q,
                                           input logic [7:0] m);
    logic [16:0] sh;
    logic [8:0]  t;
    sh = {a, q} << 1;
    t  = sh[16:8] + ~{1'b0, m} + 9'd1;
    if (t[8] == 1'b0) begin
      div_step = {t, sh[7:1], 1'b1};
    end else begin
      div_step = {sh[16:8], sh[7:1], 1'b0};
    end
  endfunction

  assign step_s = div_step(a_q, q_q, m_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      a_q     <= 9'd0;
      q_q     <= 8'd0;
      m_q     <= 8'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic; a zero divisor leaves RUN after a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ((m_q == 8'd0) || (cnt_q == 3'd7)) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = 9'd0;
          q_d   = dividend;
          m_d   = divisor;
          cnt_d = 3'd0;
          dbz_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        if (m_q == 8'd0) begin
          // Q still holds the untouched dividend here.
          quot_d = 8'hFF;
          rem_d  = q_q;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          a_d   = step_s[16:8];
          q_d   = step_s[7:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quot_d = step_s[7:0];
            rem_d  = step_s[15:8];
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: expected results from plain / and %,
// checked by a monitor whenever done is observed.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  restoring_divider dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
      e.z = 1'b1;
      e.cyc = cyc + 2;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
      e.cyc = cyc + 9;
    end
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout_%s: done not seen within 20 cycles, required done", tag);
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 ||
        div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero",
               tag, busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic monitor();
    exp_t       e;
    logic [7:0] pq = 8'd0;
    logic [7:0] pr = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (busy && done) begin
          n_bad++;
          $display("FAIL busy_done_overlap: busy=1 done=1 at cycle %0d, required not both", cyc);
        end
        if (done) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
          end else begin
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z || cyc != e.cyc) begin
              n_bad++;
              $display("FAIL result_%0d/%0d: got q=%0d r=%0d dbz=%b cyc=%0d, required q=%0d r=%0d dbz=%b cyc=%0d",
                       e.a, e.b, quotient, remainder, div_by_zero, cyc, e.q, e.r, e.z, e.cyc);
            end else if (e.b != 8'd0 &&
                         (int'(quotient) * int'(e.b) + int'(remainder) != int'(e.a) ||
                          remainder >= e.b)) begin
              n_bad++;
              $display("FAIL identity_%0d/%0d: got q=%0d r=%0d, required a=q*b+r with r<b",
                       e.a, e.b, quotient, remainder);
            end
          end
        end else if (quotient !== pq || remainder !== pr) begin
          n_bad++;
          $display("FAIL hold: q/r changed %0d/%0d -> %0d/%0d without done, required stable",
                   pq, pr, quotient, remainder);
        end
      end
      pq = quotient;
      pr = remainder;
    end
  endtask

  initial begin
    logic [7:0] ca[6];
    logic [7:0] cb[6];
    ca = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    cb = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd255};

    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_b = 1'b1;
    @(negedge clk);

    issue(8'd100, 8'd7);   wait_done("100/7");
    issue(8'd255, 8'd1);   wait_done("255/1");
    issue(8'd5, 8'd10);    wait_done("5/10");
    issue(8'd200, 8'd0);   wait_done("200/0");
    issue(8'd9, 8'd3);     wait_done("9/3");

    // Start requests while busy, plus operand changes mid-run, must be ignored.
    issue(8'd77, 8'd5);
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 8'h33;
    divisor  = 8'h00;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("77/5_ignore");

    // Asynchronous abort mid-operation.
    issue(8'd250, 8'd3);
    repeat (4) @(negedge clk);
    #1 rst_b = 1'b0;
    #1 check_zero("async_abort");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    issue(8'd250, 8'd3);   wait_done("250/3_after_reset");

    foreach (ca[i]) begin
      foreach (cb[j]) begin
        issue(ca[i], cb[j]);
        wait_done("corner");
      end
    end

    for (int n = 0; n < 3000; n++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done("random");
    end

    repeat (12) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d results pending, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_b.
REQ-002 SHALL have no parameters; the datapath is fixed at 8 bits.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst_b, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, 8 bits: unsigned dividend; sampled with start.
REQ-007 SHALL have port divisor, input, 8 bits: unsigned divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-010 SHALL have port quotient, output, 8 bits: unsigned quotient, registered.
REQ-011 SHALL have port remainder, output, 8 bits: unsigned remainder, registered.
REQ-012 SHALL have port div_by_zero, output, 1 bit: flag for the last result; set when the divisor was 0.

Function
REQ-013 SHALL implement an unsigned restoring division with one iteration per clock, using a 9-bit partial remainder A, an 8-bit shift register Q and a divisor register M.
REQ-014 SHALL use a state machine with states IDLE and RUN; reset enters IDLE.
REQ-015 In IDLE, a rising edge with start=1 (edge E0) SHALL latch M=divisor, Q=dividend, A=0 and iteration count=0, set busy=1, clear div_by_zero, and enter RUN.
REQ-016 Each RUN edge SHALL perform one iteration:
- shift {A,Q} left by 1;
- compute T = A - {1'b0,M} in 9 bits, as A + ~{0,M} + 1 (adder with carry-in = 1);
- if T[8]=0: A=T and Q[0]=1;
- else: keep the shifted A and set Q[0]=0.
REQ-017 At the 8th iteration edge (E8), the block SHALL load quotient=Q and remainder=A[7:0] with the final-iteration values, set done=1 for exactly one cycle, set busy=0, and return to IDLE.
REQ-018 Latency SHALL be 8 clocks from the start edge to the done edge; throughput SHALL be one division per 9 cycles at best (a new start is accepted at E8+1).
REQ-019 If divisor=0 at E0, the block SHALL skip iterations: at E1 it SHALL set quotient=8'hFF, remainder=dividend, div_by_zero=1, done=1 and busy=0, and return to IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from done until the next done or reset; they SHALL NOT change mid-operation.
REQ-022 dividend and divisor SHALL be don't-care after E0; changes during RUN SHALL NOT affect the result.
REQ-023 The results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor whenever divisor != 0.
REQ-024 done and busy SHALL never be high in the same cycle.

Reset
REQ-025 While rst_b=0, asynchronously: state=IDLE, count=0, A=0, Q=0, M=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_b deassertion SHALL operate normally.

Verification
REQ-027 Bench SHALL drive dividend=100, divisor=7, start at E0 -> done at E8 only, quotient=14, remainder=2, div_by_zero=0.
REQ-028 Bench SHALL drive 255/1 and then 5/10 back-to-back (second start in the cycle after done) -> 255 r0, then 0 r5, each with 8-cycle latency.
REQ-029 Bench SHALL drive 200/0 -> done at E1, quotient=8'hFF, remainder=8'hC8, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-030 Bench SHALL start 77/5 and then pulse start with 9/2 and change the inputs at E3 -> ignored; result 15 r2 at E8.
REQ-031 Bench SHALL start 250/3 and assert rst_b=0 after E4 -> all outputs 0 immediately, no done pulse; after release, 250/3 -> 83 r1.
REQ-032 Bench SHALL run exhaustive or random checks of all 65536 operand pairs against REQ-019 and REQ-023 -> zero mismatches.
